// File: rtl/vec_mem_arb_ctrl_if.sv
//------------------------------------------------------------------------------
// vec_mem_arb_ctrl_if : two-port request/response bundle for vec_mem_arb_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface vec_mem_arb_ctrl_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 18
);
  logic [1:0]                          req_valid;
  logic [1:0]                          req_ready;
  logic [1:0]                          req_wren;
  logic [1:0][ADDR_W-1:0]              req_addr;
  logic [1:0][LANES-1:0]               req_lane_mask;
  logic [1:0][LANES-1:0][LANE_W-1:0]   req_wdata;
  logic [1:0]                          rsp_valid;
  logic [LANES-1:0][LANE_W-1:0]        rsp_rdata;
  logic                                rsp_err;

  modport master (
    output req_valid, req_wren, req_addr, req_lane_mask, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_lane_mask, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/vec_mem_arb_ctrl.sv
//------------------------------------------------------------------------------
// vec_mem_arb_ctrl : two-requestor vector memory controller with lane-masked
// writes, READ_LAT 1/2 response pipeline and range check.
// Optional macro VMEM_RR_ARB_EN selects round-robin instead of fixed priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vec_mem_arb_ctrl #(
  parameter int LANES    = 16,
  parameter int LANE_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vec_mem_arb_ctrl_if.slave bus
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef logic [LANES-1:0][LANE_W-1:0] row_t;

  logic [1:0]        w_grant;
  logic              w_acc;
  logic              w_port;
  logic              w_sel_wren;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LANES-1:0]  w_sel_mask;
  row_t              w_sel_wdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

`ifdef VMEM_RR_ARB_EN
  // Port of the previous accepted request; reset value 1 hands the first conflict to port 0.
  logic r_last;

  always_comb begin
    w_grant = 2'b00;
    if (!rst) begin
      if (&bus.req_valid) begin
        w_grant = r_last ? 2'b01 : 2'b10;
      end else begin
        w_grant = bus.req_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_port;
    end
  end
`else
  always_comb begin
    w_grant = 2'b00;
    if (!rst) begin
      if (bus.req_valid[0]) begin
        w_grant = 2'b01;
      end else if (bus.req_valid[1]) begin
        w_grant = 2'b10;
      end
    end
  end
`endif

  assign w_acc         = |w_grant;
  assign w_port        = w_grant[1];
  assign w_sel_wren    = bus.req_wren[w_port];
  assign w_sel_addr    = bus.req_addr[w_port];
  assign w_sel_mask    = bus.req_lane_mask[w_port];
  assign w_sel_wdata   = bus.req_wdata[w_port];
  // Full-width compare so out-of-range rows never alias onto low rows.
  assign w_in_range    = ({1'b0, w_sel_addr} < c_DEPTH_EXT);
  assign w_idx         = w_sel_addr[IDX_W-1:0];
  assign bus.req_ready = w_grant;

  row_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_acc && w_sel_wren && w_in_range) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_sel_mask[l]) begin
          r_mem[w_idx][l] <= w_sel_wdata[l];
        end
      end
    end
  end

  // Stage 1: one-hot valid doubles as the port tag of the access.
  logic [1:0] r_s1_valid;
  row_t       r_s1_data;
  logic       r_s1_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 2'b00;
      r_s1_data  <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= w_grant;
      r_s1_err   <= w_acc && !w_in_range;
      if (w_acc && !w_sel_wren && w_in_range) begin
        r_s1_data <= r_mem[w_idx];
      end else begin
        r_s1_data <= '0;
      end
    end
  end

  generate
    if (READ_LAT >= 2) begin : g_lat2
      logic [1:0] r_s2_valid;
      row_t       r_s2_data;
      logic       r_s2_err;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_valid <= 2'b00;
          r_s2_data  <= '0;
          r_s2_err   <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= r_s1_data;
          r_s2_err   <= r_s1_err;
        end
      end

      assign bus.rsp_valid = r_s2_valid;
      assign bus.rsp_rdata = r_s2_data;
      assign bus.rsp_err   = r_s2_err;
    end else begin : g_lat1
      assign bus.rsp_valid = r_s1_valid;
      assign bus.rsp_rdata = r_s1_data;
      assign bus.rsp_err   = r_s1_err;
    end
  endgenerate

endmodule

`default_nettype wire
